// File: rtl/usb_audio_feature_unit_pkg.sv
// Shared constants, state encoding and volume clamp for the UAC1 Feature Unit
// control handler.
package usb_audio_pkg;

   localparam logic [7:0] REQ_SET_CUR = 8'h01;
   localparam logic [7:0] REQ_GET_CUR = 8'h81;
   localparam logic [7:0] REQ_GET_MIN = 8'h82;
   localparam logic [7:0] REQ_GET_MAX = 8'h83;
   localparam logic [7:0] REQ_GET_RES = 8'h84;

   localparam logic [7:0] CS_MUTE   = 8'h01;
   localparam logic [7:0] CS_VOLUME = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DECODE  = 3'd1,
      ST_RX_DATA = 3'd2,
      ST_APPLY   = 3'd3,
      ST_TX_DATA = 3'd4
   } state_e;

   // 16'h8000 is the UAC "-infinity" code; it maps onto the lowest supported level.
   function automatic logic [15:0] vol_clamp(input logic [15:0] vol,
                                             input logic [15:0] vmin,
                                             input logic [15:0] vmax);
      logic [15:0] res;
      if (vol == 16'h8000) begin
         res = vmin;
      end else if ($signed(vol) < $signed(vmin)) begin
         res = vmin;
      end else if ($signed(vol) > $signed(vmax)) begin
         res = vmax;
      end else begin
         res = vol;
      end
      return res;
   endfunction

endpackage

// File: rtl/usb_audio_feature_unit_if.sv
// EP0 class-request, OUT data-stage and IN data-stage signals between the
// setup decoder / packetiser (master) and the Feature Unit (slave).
interface usb_audio_feature_unit_if;
   logic        Req_Start;
   logic [7:0]  Req_Code;
   logic [15:0] Req_Value;
   logic [15:0] Req_Index;
   logic [15:0] Req_Length;
   logic [7:0]  OUT_Data;
   logic        OUT_Valid;
   logic        OUT_EoP;
   logic [7:0]  IN_Data;
   logic        IN_Valid;
   logic        IN_Ready;
   logic        IN_Last;
   logic        Req_Done;
   logic        Req_Stall;

   modport master (
      output Req_Start, Req_Code, Req_Value, Req_Index, Req_Length,
      output OUT_Data, OUT_Valid, OUT_EoP, IN_Ready,
      input  IN_Data, IN_Valid, IN_Last, Req_Done, Req_Stall
   );

   modport slave (
      input  Req_Start, Req_Code, Req_Value, Req_Index, Req_Length,
      input  OUT_Data, OUT_Valid, OUT_EoP, IN_Ready,
      output IN_Data, IN_Valid, IN_Last, Req_Done, Req_Stall
   );
endinterface

// File: rtl/usb_audio_feature_unit.sv
// UAC1 Feature Unit control handler: decodes mute/volume class requests for
// master + CHANNELS channels and exposes the settings to the audio datapath.
module usb_audio_feature_unit
   import usb_audio_pkg::*;
#(
   parameter int          CHANNELS    = 2,
   parameter logic [7:0]  UNIT_ID     = 8'h02,
   parameter logic [7:0]  INTERFACE   = 8'h00,
   parameter logic [15:0] VOL_MIN     = 16'hC400,
   parameter logic [15:0] VOL_MAX     = 16'h0000,
   parameter logic [15:0] VOL_RES     = 16'h0100,
   parameter logic [15:0] VOL_DEFAULT = 16'hF400
) (
   input  logic                          Clk,
   input  logic                          nReset,
   usb_audio_feature_unit_if.slave       ctl,
   output logic [CHANNELS:0]             Mute,
   output logic [16*(CHANNELS+1)-1:0]    Volume,
   output logic                          Changed
);

   state_e      state_q, state_d;
   logic [7:0]  code_q, code_d;
   logic [15:0] value_q, value_d;
   logic [15:0] index_q, index_d;
   logic [15:0] len_q, len_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] rx_q, rx_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  in_data_q, in_data_d;
   logic        in_valid_q, in_valid_d;
   logic        in_last_q, in_last_d;
   logic        done_q, done_d;
   logic        stall_q, stall_d;
   logic        changed_q, changed_d;

   logic        mute_q [CHANNELS+1];
   logic [15:0] vol_q  [CHANNELS+1];

   logic        legal_s;
   logic        ctl_ok_s;
   logic [1:0]  size_s;
   logic        apply_s;
   logic        mute_sel_s;
   logic [15:0] vol_sel_s;
   logic [15:0] get_val_s;

   // Decode legality, transfer size and the value a GET request returns
   always_comb begin
      mute_sel_s = 1'b0;
      vol_sel_s  = VOL_DEFAULT;
      for (int n = 0; n <= CHANNELS; n++) begin
         mute_sel_s = (value_q[7:0] == 8'(n)) ? mute_q[n] : mute_sel_s;
         vol_sel_s  = (value_q[7:0] == 8'(n)) ? vol_q[n]  : vol_sel_s;
      end
      case (value_q[15:8])
         CS_MUTE:   ctl_ok_s = (code_q == REQ_SET_CUR) || (code_q == REQ_GET_CUR);
         CS_VOLUME: ctl_ok_s = (code_q == REQ_SET_CUR) || (code_q == REQ_GET_CUR) ||
                               (code_q == REQ_GET_MIN) || (code_q == REQ_GET_MAX) ||
                               (code_q == REQ_GET_RES);
         default:   ctl_ok_s = 1'b0;
      endcase
      legal_s = ctl_ok_s && (index_q[15:8] == UNIT_ID) && (index_q[7:0] == INTERFACE) &&
                (value_q[7:0] <= 8'(CHANNELS));
      size_s  = (value_q[15:8] == CS_MUTE) ? 2'd1 : 2'd2;
      case (code_q)
         REQ_GET_CUR: get_val_s = (value_q[15:8] == CS_MUTE) ? {15'd0, mute_sel_s} : vol_sel_s;
         REQ_GET_MIN: get_val_s = VOL_MIN;
         REQ_GET_MAX: get_val_s = VOL_MAX;
         REQ_GET_RES: get_val_s = VOL_RES;
         default:     get_val_s = 16'h0000;
      endcase
   end

   // Request FSM next-state and registered-output computation
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      value_d    = value_q;
      index_d    = index_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      rx_d       = rx_q;
      hi_d       = hi_q;
      in_data_d  = in_data_q;
      in_valid_d = in_valid_q;
      in_last_d  = in_last_q;
      done_d     = 1'b0;
      stall_d    = 1'b0;
      changed_d  = 1'b0;
      apply_s    = 1'b0;
      if (ctl.Req_Start) begin
         // A new SETUP always wins: abandon whatever was in flight.
         state_d    = ST_DECODE;
         code_d     = ctl.Req_Code;
         value_d    = ctl.Req_Value;
         index_d    = ctl.Req_Index;
         len_d      = ctl.Req_Length;
         cnt_d      = 2'd0;
         in_valid_d = 1'b0;
         in_last_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_DECODE: begin
               if (!legal_s) begin
                  stall_d = 1'b1;
                  state_d = ST_IDLE;
               end else if (code_q == REQ_SET_CUR) begin
                  if (len_q != {14'd0, size_s}) begin
                     stall_d = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_RX_DATA;
                  end
               end else if (len_q == 16'd0) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_TX_DATA;
                  in_valid_d = 1'b1;
                  in_data_d  = get_val_s[7:0];
                  hi_d       = get_val_s[15:8];
                  in_last_d  = (len_q == 16'd1) || (size_s == 2'd1);
               end
            end
            ST_RX_DATA: begin
               if (!ctl.OUT_Valid) begin
                  state_d = ST_RX_DATA;
               end else if (ctl.OUT_EoP) begin
                  if (cnt_q == size_s) begin
                     state_d = ST_APPLY;
                  end else begin
                     stall_d = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else if (cnt_q == size_s) begin
                  stall_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  if (cnt_q == 2'd0) begin
                     rx_d[7:0] = ctl.OUT_Data;
                  end else begin
                     rx_d[15:8] = ctl.OUT_Data;
                  end
                  cnt_d = cnt_q + 2'd1;
               end
            end
            ST_APPLY: begin
               apply_s   = 1'b1;
               changed_d = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end
            ST_TX_DATA: begin
               if (!ctl.IN_Ready) begin
                  state_d = ST_TX_DATA;
               end else if (in_last_q) begin
                  in_valid_d = 1'b0;
                  in_last_d  = 1'b0;
                  done_d     = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  in_data_d = hi_q;
                  in_last_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Request FSM state and handshake output registers
   always_ff @(posedge Clk) begin
      if (!nReset) begin
         state_q    <= ST_IDLE;
         code_q     <= 8'h00;
         value_q    <= 16'h0000;
         index_q    <= 16'h0000;
         len_q      <= 16'h0000;
         cnt_q      <= 2'd0;
         rx_q       <= 16'h0000;
         hi_q       <= 8'h00;
         in_data_q  <= 8'h00;
         in_valid_q <= 1'b0;
         in_last_q  <= 1'b0;
         done_q     <= 1'b0;
         stall_q    <= 1'b0;
         changed_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         value_q    <= value_d;
         index_q    <= index_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         rx_q       <= rx_d;
         hi_q       <= hi_d;
         in_data_q  <= in_data_d;
         in_valid_q <= in_valid_d;
         in_last_q  <= in_last_d;
         done_q     <= done_d;
         stall_q    <= stall_d;
         changed_q  <= changed_d;
      end
   end

   for (genvar g = 0; g <= CHANNELS; g++) begin : g_ch
      // Per-channel mute/volume control set, written only on APPLY
      always_ff @(posedge Clk) begin
         if (!nReset) begin
            mute_q[g] <= 1'b0;
            vol_q[g]  <= VOL_DEFAULT;
         end else if (apply_s && (value_q[7:0] == 8'(g))) begin
            if (value_q[15:8] == CS_MUTE) begin
               mute_q[g] <= rx_q[0];
            end else begin
               vol_q[g] <= vol_clamp(rx_q, VOL_MIN, VOL_MAX);
            end
         end
      end
      assign Mute[g]            = mute_q[g];
      assign Volume[16*g +: 16] = vol_q[g];
   end

   assign ctl.IN_Data   = in_data_q;
   assign ctl.IN_Valid  = in_valid_q;
   assign ctl.IN_Last   = in_last_q;
   assign ctl.Req_Done  = done_q;
   assign ctl.Req_Stall = stall_q;
   assign Changed       = changed_q;

endmodule

// File: tb/tb_usb_audio_feature_unit.sv
// Self-checking bench for usb_audio_feature_unit: directed scenarios plus
// randomized requests checked against a request-level reference model.
module tb_usb_audio_feature_unit;

   logic        Clk = 1'b0;
   logic        nReset = 1'b0;
   logic [2:0]  Mute;
   logic [47:0] Volume;
   logic        Changed;

   usb_audio_feature_unit_if bus();

   usb_audio_feature_unit dut (
      .Clk    (Clk),
      .nReset (nReset),
      .ctl    (bus),
      .Mute   (Mute),
      .Volume (Volume),
      .Changed(Changed)
   );

   always #5 Clk = ~Clk;

   int vec_cnt = 0;
   int err_cnt = 0;
   int done_cnt = 0;
   int stall_cnt = 0;
   int chg_cnt = 0;
   int ready_mode = 0;
   logic [8:0] in_q[$];
   logic [8:0] exp_q[$];
   logic       m_mute[3];
   logic [15:0] m_vol[3];

   // Pulse counters and IN handshake capture, sampled away from the active edge
   always @(negedge Clk) begin
      if (bus.Req_Done === 1'b1) done_cnt++;
      if (bus.Req_Stall === 1'b1) stall_cnt++;
      if (Changed === 1'b1) chg_cnt++;
      if (bus.IN_Valid === 1'b1 && bus.IN_Ready === 1'b1) in_q.push_back({bus.IN_Last, bus.IN_Data});
   end

   // IN_Ready pattern: 0 = always ready, 1 = random, other = held low
   always @(posedge Clk) begin
      #1;
      case (ready_mode)
         0: bus.IN_Ready = 1'b1;
         1: bus.IN_Ready = ($urandom_range(0, 3) != 0);
         default: bus.IN_Ready = 1'b0;
      endcase
   end

   function automatic logic [15:0] ref_clamp(input logic [15:0] raw);
      int v;
      v = int'($signed(raw));
      if (v < -15360) return 16'hC400;
      if (v > 0) return 16'h0000;
      return raw;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_mute[i] = 1'b0;
         m_vol[i]  = 16'hF400;
      end
   endtask

   function automatic logic [2:0] exp_mute();
      return {m_mute[2], m_mute[1], m_mute[0]};
   endfunction

   function automatic logic [47:0] exp_vol();
      return {m_vol[2], m_vol[1], m_vol[0]};
   endfunction

   // Request-level model: what the host should observe for one whole request
   task automatic model_txn(input logic [7:0] code, input logic [15:0] value, input logic [15:0] index,
                            input logic [15:0] len, input int nb, input logic [7:0] d[3],
                            output int e_done, output int e_stall, output int e_chg);
      int sel, ch, size, n;
      bit legal;
      logic [15:0] val;
      sel = int'(value[15:8]);
      ch  = int'(value[7:0]);
      size = (sel == 1) ? 1 : 2;
      legal = (index == 16'h0200) && (ch <= 2) &&
              ((sel == 1 && (code == 8'h01 || code == 8'h81)) ||
               (sel == 2 && (code == 8'h01 || (code >= 8'h81 && code <= 8'h84))));
      e_done = 0; e_stall = 0; e_chg = 0;
      exp_q.delete();
      if (!legal) begin
         e_stall = 1;
      end else if (code == 8'h01) begin
         if (int'(len) != size || nb != size) begin
            e_stall = 1;
         end else begin
            e_done = 1; e_chg = 1;
            if (sel == 1) m_mute[ch] = d[0][0];
            else m_vol[ch] = ref_clamp({d[1], d[0]});
         end
      end else begin
         e_done = 1;
         if (code == 8'h81) val = (sel == 1) ? {15'd0, m_mute[ch]} : m_vol[ch];
         else if (code == 8'h82) val = 16'hC400;
         else if (code == 8'h83) val = 16'h0000;
         else val = 16'h0100;
         n = (int'(len) < size) ? int'(len) : size;
         for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, (i == 0) ? val[7:0] : val[15:8]});
         end
      end
   endtask

   task automatic start_req(input logic [7:0] code, input logic [15:0] value,
                            input logic [15:0] index, input logic [15:0] len);
      @(negedge Clk);
      bus.Req_Code = code; bus.Req_Value = value; bus.Req_Index = index; bus.Req_Length = len;
      bus.Req_Start = 1'b1;
      @(negedge Clk);
      bus.Req_Start = 1'b0;
   endtask

   // Drive one request end to end and wait (bounded) for its Done/Stall pulse
   task automatic run_txn(input logic [7:0] code, input logic [15:0] value, input logic [15:0] index,
                          input logic [15:0] len, input int nb, input logic [7:0] d[3],
                          output bit timed_out);
      int d0, s0;
      d0 = done_cnt; s0 = stall_cnt;
      start_req(code, value, index, len);
      if (code == 8'h01) begin
         @(negedge Clk);
         for (int i = 0; i < nb; i++) begin
            bus.OUT_Valid = 1'b1; bus.OUT_Data = d[i];
            @(negedge Clk);
         end
         bus.OUT_Valid = 1'b1; bus.OUT_EoP = 1'b1; bus.OUT_Data = 8'h00;
         @(negedge Clk);
         bus.OUT_Valid = 1'b0; bus.OUT_EoP = 1'b0;
      end
      timed_out = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (done_cnt != d0 || stall_cnt != s0) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge Clk);
      end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_reset();
      vec_cnt++;
      if (Mute !== 3'b000 || Volume !== {3{16'hF400}}) begin
         err_cnt++; $display("FAIL reset_settings: mute=%b vol=%h required 000 / %h", Mute, Volume, {3{16'hF400}});
      end
      vec_cnt++;
      if ({bus.IN_Valid, bus.IN_Last, bus.Req_Done, bus.Req_Stall, Changed} !== 5'b00000) begin
         err_cnt++; $display("FAIL reset_pulses: got %b required 00000",
                             {bus.IN_Valid, bus.IN_Last, bus.Req_Done, bus.Req_Stall, Changed});
      end
   endtask

   task automatic test_get_cur();
      int d0;
      ready_mode = 0;
      in_q.delete(); d0 = done_cnt;
      start_req(8'h81, 16'h0201, 16'h0200, 16'd2);
      vec_cnt++;
      if (bus.IN_Valid !== 1'b0) begin
         err_cnt++; $display("FAIL get_cur_early_valid: IN_Valid=%b required 0", bus.IN_Valid);
      end
      @(negedge Clk);
      vec_cnt++;
      if (bus.IN_Valid !== 1'b1 || bus.IN_Data !== 8'h00 || bus.IN_Last !== 1'b0) begin
         err_cnt++; $display("FAIL get_cur_first_byte: v=%b d=%h l=%b required 1 00 0",
                             bus.IN_Valid, bus.IN_Data, bus.IN_Last);
      end
      for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge Clk);
      vec_cnt++;
      if (in_q.size() != 2 || in_q[0] !== 9'h000 || in_q[1] !== 9'h1F4 || done_cnt != d0 + 1) begin
         err_cnt++; $display("FAIL get_cur_bytes: n=%0d done=%0d required 2 bytes 000,1F4 and one done",
                             in_q.size(), done_cnt - d0);
      end
   endtask

   task automatic test_set_vol();
      bit to;
      int c0, ed, es, ec;
      c0 = chg_cnt;
      model_txn(8'h01, 16'h0202, 16'h0200, 16'd2, 2, '{8'h00, 8'h10, 8'h00}, ed, es, ec);
      run_txn(8'h01, 16'h0202, 16'h0200, 16'd2, 2, '{8'h00, 8'h10, 8'h00}, to);
      vec_cnt++;
      if (to || Volume[47:32] !== 16'h0000 || chg_cnt != c0 + 1) begin
         err_cnt++; $display("FAIL set_vol_clamp_max: vol2=%h chg=%0d to=%0d required 0000 1 0",
                             Volume[47:32], chg_cnt - c0, to);
      end
      model_txn(8'h01, 16'h0202, 16'h0200, 16'd2, 2, '{8'h00, 8'h80, 8'h00}, ed, es, ec);
      run_txn(8'h01, 16'h0202, 16'h0200, 16'd2, 2, '{8'h00, 8'h80, 8'h00}, to);
      vec_cnt++;
      if (to || Volume !== exp_vol() || Volume[47:32] !== 16'hC400) begin
         err_cnt++; $display("FAIL set_vol_neg_inf: vol=%h required %h", Volume, exp_vol());
      end
   endtask

   task automatic test_mute();
      bit to;
      int ed, es, ec;
      model_txn(8'h01, 16'h0100, 16'h0200, 16'd1, 1, '{8'h01, 8'h00, 8'h00}, ed, es, ec);
      run_txn(8'h01, 16'h0100, 16'h0200, 16'd1, 1, '{8'h01, 8'h00, 8'h00}, to);
      vec_cnt++;
      if (to || Mute !== 3'b001) begin
         err_cnt++; $display("FAIL set_mute: mute=%b required 001", Mute);
      end
      in_q.delete();
      run_txn(8'h81, 16'h0100, 16'h0200, 16'd2, 0, '{8'h00, 8'h00, 8'h00}, to);
      vec_cnt++;
      if (to || in_q.size() != 1 || in_q[0] !== 9'h101) begin
         err_cnt++; $display("FAIL get_mute: n=%0d first=%h required 1 byte 101", in_q.size(),
                             (in_q.size() > 0) ? in_q[0] : 9'h0);
      end
   endtask

   task automatic test_rejects();
      logic [7:0]  codes[4]  = '{8'h82, 8'h81, 8'h81, 8'h01};
      logic [15:0] values[4] = '{16'h0101, 16'h0203, 16'h0201, 16'h0201};
      logic [15:0] idxs[4]   = '{16'h0200, 16'h0200, 16'h0300, 16'h0200};
      logic [15:0] lens[4]   = '{16'd1, 16'd2, 16'd2, 16'd1};
      bit to;
      int s0, d0, c0;
      for (int i = 0; i < 4; i++) begin
         s0 = stall_cnt; d0 = done_cnt; c0 = chg_cnt; in_q.delete();
         run_txn(codes[i], values[i], idxs[i], lens[i], 1, '{8'h55, 8'h00, 8'h00}, to);
         vec_cnt++;
         if (to || stall_cnt != s0 + 1 || done_cnt != d0 || chg_cnt != c0 || in_q.size() != 0 ||
             Mute !== exp_mute() || Volume !== exp_vol()) begin
            err_cnt++; $display("FAIL reject_%0d: stall=%0d done=%0d chg=%0d vol=%h required 1 0 0 %h",
                                i, stall_cnt - s0, done_cnt - d0, chg_cnt - c0, Volume, exp_vol());
         end
      end
   endtask

   task automatic test_backpressure();
      int d0;
      ready_mode = 2;
      repeat (2) @(negedge Clk);
      in_q.delete(); d0 = done_cnt;
      start_req(8'h83, 16'h0201, 16'h0200, 16'd1);
      @(negedge Clk);
      for (int i = 0; i < 5; i++) begin
         vec_cnt++;
         if (bus.IN_Valid !== 1'b1 || bus.IN_Data !== 8'h00 || bus.IN_Last !== 1'b1) begin
            err_cnt++; $display("FAIL hold_stable_%0d: v=%b d=%h l=%b required 1 00 1",
                                i, bus.IN_Valid, bus.IN_Data, bus.IN_Last);
         end
         @(negedge Clk);
      end
      ready_mode = 0;
      for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge Clk);
      vec_cnt++;
      if (in_q.size() != 1 || in_q[0] !== 9'h100 || done_cnt != d0 + 1) begin
         err_cnt++; $display("FAIL get_max_len1: n=%0d done=%0d required 1 byte 100 and one done",
                             in_q.size(), done_cnt - d0);
      end
   endtask

   task automatic test_abort();
      int d0;
      ready_mode = 2;
      repeat (2) @(negedge Clk);
      d0 = done_cnt;
      start_req(8'h81, 16'h0201, 16'h0200, 16'd2);
      repeat (2) @(negedge Clk);
      in_q.delete();
      start_req(8'h84, 16'h0200, 16'h0200, 16'd2);
      vec_cnt++;
      if (bus.IN_Valid !== 1'b0) begin
         err_cnt++; $display("FAIL abort_drop_valid: IN_Valid=%b required 0", bus.IN_Valid);
      end
      ready_mode = 0;
      for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge Clk);
      repeat (2) @(negedge Clk);
      vec_cnt++;
      if (in_q.size() != 2 || in_q[0] !== 9'h000 || in_q[1] !== 9'h101 || done_cnt != d0 + 1) begin
         err_cnt++; $display("FAIL abort_new_req: n=%0d done=%0d required 000,101 and one done",
                             in_q.size(), done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid();
      int c0, d0;
      c0 = chg_cnt; d0 = done_cnt;
      start_req(8'h01, 16'h0201, 16'h0200, 16'd2);
      @(negedge Clk);
      bus.OUT_Valid = 1'b1; bus.OUT_Data = 8'h00;
      @(negedge Clk);
      bus.OUT_Valid = 1'b0;
      nReset = 1'b0;
      @(negedge Clk);
      nReset = 1'b1;
      model_reset();
      bus.OUT_Valid = 1'b1; bus.OUT_Data = 8'hF0;
      @(negedge Clk);
      bus.OUT_EoP = 1'b1; bus.OUT_Data = 8'h00;
      @(negedge Clk);
      bus.OUT_Valid = 1'b0; bus.OUT_EoP = 1'b0;
      repeat (3) @(negedge Clk);
      vec_cnt++;
      if (Mute !== 3'b000 || Volume !== {3{16'hF400}} || chg_cnt != c0 || done_cnt != d0) begin
         err_cnt++; $display("FAIL reset_mid_rx: mute=%b vol=%h chg=%0d done=%0d required 000 %h 0 0",
                             Mute, Volume, chg_cnt - c0, done_cnt - d0, {3{16'hF400}});
      end
   endtask

   task automatic test_random();
      logic [7:0] code_tbl[6] = '{8'h01, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
      logic [7:0] code, sel, ch, d[3];
      logic [15:0] index, len;
      int nb, size, ed, es, ec, d0, s0, c0;
      bit to;
      ready_mode = 1;
      for (int t = 0; t < 80; t++) begin
         code  = (t % 2 == 0) ? 8'h01 : code_tbl[$urandom_range(0, 5)];
         sel   = ($urandom_range(0, 5) == 0) ? 8'h03 : 8'($urandom_range(1, 2));
         ch    = 8'($urandom_range(0, 3));
         index = ($urandom_range(0, 7) == 0) ? 16'h0300 : 16'h0200;
         size  = (sel == 8'h01) ? 1 : 2;
         len   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'(size);
         if ($urandom_range(0, 9) == 0) len = 16'h0040;
         nb    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : size;
         for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
         model_txn(code, {sel, ch}, index, len, nb, d, ed, es, ec);
         d0 = done_cnt; s0 = stall_cnt; c0 = chg_cnt; in_q.delete();
         run_txn(code, {sel, ch}, index, len, nb, d, to);
         vec_cnt++;
         if (to || done_cnt - d0 != ed || stall_cnt - s0 != es || chg_cnt - c0 != ec) begin
            err_cnt++; $display("FAIL rnd_pulses t=%0d code=%h val=%h len=%0d: done=%0d stall=%0d chg=%0d required %0d %0d %0d",
                                t, code, {sel, ch}, len, done_cnt - d0, stall_cnt - s0, chg_cnt - c0, ed, es, ec);
         end
         vec_cnt++;
         if (in_q != exp_q) begin
            err_cnt++; $display("FAIL rnd_in_bytes t=%0d: got %0d bytes required %0d bytes", t, in_q.size(), exp_q.size());
         end
         vec_cnt++;
         if (Mute !== exp_mute() || Volume !== exp_vol()) begin
            err_cnt++; $display("FAIL rnd_settings t=%0d: mute=%b vol=%h required %b %h",
                                t, Mute, Volume, exp_mute(), exp_vol());
         end
      end
      ready_mode = 0;
   endtask

   initial begin
      bus.Req_Start = 1'b0; bus.Req_Code = 8'h00; bus.Req_Value = 16'h0000;
      bus.Req_Index = 16'h0000; bus.Req_Length = 16'h0000;
      bus.OUT_Data = 8'h00; bus.OUT_Valid = 1'b0; bus.OUT_EoP = 1'b0;
      bus.IN_Ready = 1'b1;
      model_reset();
      nReset = 1'b0;
      repeat (3) @(negedge Clk);
      nReset = 1'b1;
      @(negedge Clk);
      test_reset();
      test_get_cur();
      test_set_vol();
      test_mute();
      test_rejects();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
